// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one word request in flight,
// and buffers returned words with their PCs in an in-order queue for the decoder.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_n,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam logic [PtrW:0] CntFull = (PtrW + 1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDiscard
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic [31:0]       inst_mem_q [QUEUE_DEPTH];
    logic [31:0]       pc_mem_q   [QUEUE_DEPTH];

    logic push;
    logic pop;

    // Request is also held low during reset so no grant is taken before the first clean cycle.
    assign mem_req_o    = rst_n && (state_q == StIdle) && (count_q < CntFull) && !redirect_i;
    assign mem_addr_o   = pc_q;
    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign inst_pc_o    = inst_valid_o ? pc_mem_q[rd_ptr_q] : 32'h0;
    assign pop          = inst_valid_o && inst_ready_i && !redirect_i;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_req_o && mem_gnt_i) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
            StDiscard: begin
                if (mem_rvalid_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides everything; an in-flight word without its rvalid must be dropped later.
        if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
            push = 1'b0;
            unique case (state_q)
                StIdle:    state_d = StIdle;
                StWait:    state_d = mem_rvalid_i ? StIdle : StDiscard;
                StDiscard: state_d = mem_rvalid_i ? StIdle : StDiscard;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk_in) begin
        if (rst_n && push) begin
            inst_mem_q[wr_ptr_q] <= mem_rdata_i;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: random memory responder and decoder, checked cycle by cycle
// against a queue-based model of the fetch unit.
module tb_inst_fetch_ctrl;

    localparam int unsigned Depth   = 4;
    localparam logic [31:0] ResetPc = 32'h0000_0000;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    always #5 clk_in = ~clk_in;

    inst_fetch_ctrl #(
        .RESET_PC    (ResetPc),
        .QUEUE_DEPTH (Depth)
    ) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned grants      = 0;

    // Reference model: words owed to the decoder, fetch PC, and the single in-flight request.
    entry_t      mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_out;
    bit          m_drop;

    // Memory responder stimulus state.
    bit r_pend;
    int r_cnt;

    int  p_gnt;
    int  p_ready;
    int  p_redir;
    int  p_rst_permille;
    bit  force_rst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc     = ResetPc;
        m_req_pc = 32'h0;
        m_out    = 1'b0;
        m_drop   = 1'b0;
    endtask

    task automatic step();
        logic   exp_req;
        entry_t head;
        entry_t e;
        @(negedge clk_in);
        rst_n         = !(force_rst || ($urandom_range(0, 999) < p_rst_permille));
        mem_gnt_i     = ($urandom_range(0, 99) < p_gnt) && !r_pend;
        mem_rvalid_i  = r_pend && (r_cnt == 0);
        mem_rdata_i   = $urandom;
        redirect_i    = ($urandom_range(0, 99) < p_redir);
        redirect_pc_i = $urandom;
        inst_ready_i  = ($urandom_range(0, 99) < p_ready);
        #1;
        exp_req = rst_n && !m_out && (mq.size() < Depth) && !redirect_i;
        head    = (mq.size() != 0) ? mq[0] : '0;
        check("mem_req", {31'h0, mem_req_o}, {31'h0, exp_req});
        check("mem_addr", mem_addr_o, m_pc);
        check("inst_valid", {31'h0, inst_valid_o}, {31'h0, (mq.size() != 0)});
        check("inst", inst_o, head.word);
        check("inst_pc", inst_pc_o, head.pc);
        if (mem_req_o === 1'b1 && mem_gnt_i) grants++;
        @(posedge clk_in);
        if (mem_rvalid_i) r_pend = 1'b0;
        else if (r_pend) r_cnt--;
        if (exp_req && mem_gnt_i) begin
            r_pend = 1'b1;
            r_cnt  = $urandom_range(0, 2);
        end
        if (!rst_n) begin
            model_reset();
        end else if (redirect_i) begin
            mq.delete();
            m_pc = {redirect_pc_i[31:2], 2'b00};
            if (m_out && mem_rvalid_i) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
        end else begin
            if (mq.size() != 0 && inst_ready_i) void'(mq.pop_front());
            if (m_out && mem_rvalid_i) begin
                if (!m_drop) begin
                    e.pc   = m_req_pc;
                    e.word = mem_rdata_i;
                    mq.push_back(e);
                end
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (exp_req && mem_gnt_i) begin
                m_out    = 1'b1;
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        mem_gnt_i      = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = 32'h0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        inst_ready_i   = 1'b0;
        r_pend         = 1'b0;
        r_cnt          = 0;
        force_rst      = 1'b0;
        p_rst_permille = 0;
        p_redir        = 0;
        model_reset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid_o}, 32'h0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_inst_pc", inst_pc_o, 32'h0);
        check("rst_addr", mem_addr_o, ResetPc);

        // Streaming: immediate grant, fast decoder.
        p_gnt = 100; p_ready = 100;
        repeat (30) step();

        // Back-pressure: queue fills to exactly Depth words, then one pop buys one request.
        force_rst = 1'b1;
        step();
        force_rst = 1'b0;
        grants = 0;
        p_ready = 0;
        repeat (20) step();
        check("full_grants", grants, 32'd4);
        check("full_req_low", {31'h0, mem_req_o}, 32'h0);
        p_ready = 100;
        step();
        p_ready = 0;
        repeat (10) step();
        check("refill_grants", grants, 32'd5);

        // Mixed traffic with redirects and occasional mid-flight resets.
        p_gnt = 70; p_ready = 70; p_redir = 8; p_rst_permille = 5;
        repeat (3000) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
